// File: rtl/gpio_in_cond_pkg10.sv
// Shared types for the GPIO input-conditioning stage (gpio_in_cond10).
// Debounce counters exist only when GPIO_IN_DEBOUNCE_EN is defined.
`ifndef GPIO_DATA_WIDTH10
`define GPIO_DATA_WIDTH10 32
`endif

package gpio_in_cond_pkg10;

  localparam int unsigned DEB_CNT_W_DEFAULT = 4;

  typedef logic [DEB_CNT_W_DEFAULT-1:0] deb_cnt_t;

  typedef enum logic [1:0] {
    EDGE_FALL = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_sel_e;

  // irq_any takes priority over irq_pos
  function automatic edge_sel_e edge_sel(input logic any, input logic pos);
    if (any) begin
      return EDGE_ANY;
    end else if (pos) begin
      return EDGE_RISE;
    end
    return EDGE_FALL;
  endfunction

  function automatic logic edge_hit(input edge_sel_e sel, input logic rise,
                                    input logic fall);
    logic hit;
    case (sel)
      EDGE_ANY:  hit = rise | fall;
      EDGE_RISE: hit = rise;
      default:   hit = fall;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_pin_filter10.sv
// One GPIO pin: two-flop synchroniser, optional debounce (GPIO_IN_DEBOUNCE_EN)
// and registered edge event on each change of the debounced value.
module gpio_pin_filter10
  import gpio_in_cond_pkg10::*;
#(
  parameter int unsigned DEB_CNT_W = DEB_CNT_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pin_i,
  input  logic                 oe_n_i,
  input  logic [DEB_CNT_W-1:0] limit_i,
  input  edge_sel_e            sel_i,
  output logic                 deb_o,
  output logic                 event_o
);

  logic s1_q;
  logic s2_q;
  logic deb_q;
  logic deb_d;
  logic event_q;
  logic event_d;
  logic rise;
  logic fall;

  always_comb begin
    rise    = ~deb_q & deb_d;
    fall    = deb_q & ~deb_d;
    event_d = oe_n_i & edge_hit(sel_i, rise, fall);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= 1'b0;
      event_q <= 1'b0;
    end else begin
      s1_q    <= pin_i;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      event_q <= event_d;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] cnt_d;

  // cnt only runs while s2 disagrees with deb; any agreement restarts it
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == limit_i) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DEB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^limit_i;
  assign deb_d        = s2_q;
`endif

  assign deb_o   = deb_q;
  assign event_o = event_q;

endmodule

// File: rtl/gpio_in_cond10.sv
// GPIO input conditioning: per-pin filter, sticky status and combined interrupt.
// Debounce hardware is enabled by defining GPIO_IN_DEBOUNCE_EN.
`ifndef GPIO_DATA_WIDTH10
`define GPIO_DATA_WIDTH10 32
`endif

module gpio_in_cond10
  import gpio_in_cond_pkg10::*;
#(
  parameter int unsigned DATA_WIDTH = `GPIO_DATA_WIDTH10,
  parameter int unsigned DEB_CNT_W  = DEB_CNT_W_DEFAULT
) (
  input  logic                  pclk10,
  input  logic                  n_p_reset10,
  input  logic [DATA_WIDTH-1:0] gpio_pin_in10,
  input  logic [DATA_WIDTH-1:0] n_gpio_pin_oe10,
  input  logic [DEB_CNT_W-1:0]  deb_limit10,
  input  logic [DATA_WIDTH-1:0] irq_en10,
  input  logic [DATA_WIDTH-1:0] irq_pos10,
  input  logic [DATA_WIDTH-1:0] irq_any10,
  input  logic [DATA_WIDTH-1:0] irq_clr10,
  output logic [DATA_WIDTH-1:0] gpio_data_in10,
  output logic [DATA_WIDTH-1:0] irq_status10,
  output logic                  irq10
);

  logic [DATA_WIDTH-1:0] deb_w;
  logic [DATA_WIDTH-1:0] event_w;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] status_d;
  logic                  irq_q;
  logic                  irq_d;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
    gpio_pin_filter10 #(
      .DEB_CNT_W (DEB_CNT_W)
    ) u_filter (
      .clk_i   (pclk10),
      .rst_ni  (n_p_reset10),
      .pin_i   (gpio_pin_in10[i]),
      .oe_n_i  (n_gpio_pin_oe10[i]),
      .limit_i (deb_limit10),
      .sel_i   (edge_sel(irq_any10[i], irq_pos10[i])),
      .deb_o   (deb_w[i]),
      .event_o (event_w[i])
    );
  end

  // A new event overrides a clear landing in the same cycle
  always_comb begin
    status_d = (status_q & ~irq_clr10) | event_w;
    irq_d    = |(status_q & irq_en10);
  end

  always_ff @(posedge pclk10 or negedge n_p_reset10) begin
    if (!n_p_reset10) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign gpio_data_in10 = deb_w;
  assign irq_status10   = status_q;
  assign irq10          = irq_q;

endmodule

// File: tb/tb_gpio_in_cond10.sv
// Directed bench for gpio_in_cond10: expected values are queued with the cycle
// at which they must appear and compared on the falling clock edge.
module tb_gpio_in_cond10;
  import gpio_in_cond_pkg10::*;

  localparam int          W     = 8;
  localparam int          CW    = 4;
  localparam int unsigned LIMIT = 3;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned L = LIMIT;
`else
  localparam int unsigned L = 0;
`endif

  localparam int K_DATA = 0;
  localparam int K_STAT = 1;
  localparam int K_IRQ  = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          idx;
    logic        val;
    string       tag;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pins;
  logic [W-1:0]  oe_n;
  logic [CW-1:0] limit;
  logic [W-1:0]  en;
  logic [W-1:0]  pos;
  logic [W-1:0]  any;
  logic [W-1:0]  clr;
  logic [W-1:0]  data;
  logic [W-1:0]  status;
  logic          irq;

  int unsigned cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          fail_cnt = 0;
  ent_t        sbq[$];

  gpio_in_cond10 #(
    .DATA_WIDTH (W),
    .DEB_CNT_W  (CW)
  ) dut (
    .pclk10          (clk),
    .n_p_reset10     (rst_n),
    .gpio_pin_in10   (pins),
    .n_gpio_pin_oe10 (oe_n),
    .deb_limit10     (limit),
    .irq_en10        (en),
    .irq_pos10       (pos),
    .irq_any10       (any),
    .irq_clr10       (clr),
    .gpio_data_in10  (data),
    .irq_status10    (status),
    .irq10           (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int unsigned at, input int kind,
                                    input int idx, input logic v, input string tag);
    ent_t e;
    e.cyc  = at;
    e.kind = kind;
    e.idx  = idx;
    e.val  = v;
    e.tag  = tag;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    ent_t keep[$];
    logic obs;
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].cyc == cyc) begin
        case (sbq[i].kind)
          K_DATA:  obs = data[sbq[i].idx];
          K_STAT:  obs = status[sbq[i].idx];
          default: obs = irq;
        endcase
        total_cnt++;
        assert (obs === sbq[i].val) pass_cnt++;
        else begin
          fail_cnt++;
          $error("FAIL %s[%0d] cycle %0d: observed %b expected %b",
                 sbq[i].tag, sbq[i].idx, cyc, obs, sbq[i].val);
        end
      end else if (sbq[i].cyc < cyc) begin
        total_cnt++;
        fail_cnt++;
        $error("FAIL %s[%0d]: check at cycle %0d not sampled, now %0d",
               sbq[i].tag, sbq[i].idx, sbq[i].cyc, cyc);
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  end

  task automatic clear_pin(input int idx);
    int unsigned n;
    @(negedge clk);
    clr[idx] = 1'b1;
    n = cyc + 1;
    expect_at(n, K_STAT, idx, 1'b0, "clr_status");
    expect_at(n + 1, K_IRQ, 0, 1'b0, "clr_irq");
    @(negedge clk);
    clr[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_pin(input int idx, input logic v, input logic ev,
                           input logic irq_exp);
    int unsigned e0;
    @(negedge clk);
    pins[idx] = v;
    e0 = cyc + 1;
    expect_at(e0 + 1 + L, K_DATA, idx, ~v, "data_hold");
    expect_at(e0 + 2 + L, K_DATA, idx, v, "data_upd");
    expect_at(e0 + 2 + L, K_STAT, idx, 1'b0, "status_pre");
    expect_at(e0 + 3 + L, K_STAT, idx, ev, "status_evt");
    expect_at(e0 + 3 + L, K_IRQ, 0, 1'b0, "irq_pre");
    expect_at(e0 + 4 + L, K_IRQ, 0, irq_exp, "irq_evt");
    repeat (5 + L) @(negedge clk);
    if (ev) clear_pin(idx);
  endtask

  task automatic pulse_pin(input int idx, input int unsigned p);
    int unsigned e0;
    logic        hit;
    hit = (p >= L + 1);
    @(negedge clk);
    pins[idx] = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 1 + L, K_DATA, idx, 1'b0, "pulse_hold");
    expect_at(e0 + 2 + L, K_DATA, idx, hit, "pulse_rise");
    expect_at(e0 + p + 1 + L, K_DATA, idx, hit, "pulse_high");
    expect_at(e0 + p + 2 + L, K_DATA, idx, 1'b0, "pulse_fall");
    expect_at(e0 + 3 + L, K_STAT, idx, hit, "pulse_status");
    expect_at(e0 + p + 3 + L, K_STAT, idx, hit, "pulse_status_end");
    expect_at(e0 + 4 + L, K_IRQ, 0, hit, "pulse_irq");
    repeat (p) @(negedge clk);
    pins[idx] = 1'b0;
    repeat (p + L + 4) @(negedge clk);
    if (hit) clear_pin(idx);
  endtask

  initial begin
    int unsigned e0;
    int unsigned waited;
    logic [W-1:0] exp_st;

    rst_n = 1'b0;
    pins  = '0;
    oe_n  = 8'hF7;          // pin3 is an output
    limit = CW'(LIMIT);
    en    = '1;
    pos   = 8'hEF;          // pin4 falling-edge only
    any   = 8'h04;          // pin2 both edges
    clr   = '0;

    #1;
    total_cnt++;
    assert (data === '0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL reset_data: observed %h expected 00", data); end
    total_cnt++;
    assert (status === '0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL reset_status: observed %h expected 00", status); end
    total_cnt++;
    assert (irq === 1'b0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL reset_irq: observed %b expected 0", irq); end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_at(cyc + 4, K_DATA, 0, 1'b0, "idle_data");
    expect_at(cyc + 4, K_STAT, 0, 1'b0, "idle_status");
    expect_at(cyc + 4, K_IRQ, 0, 1'b0, "idle_irq");
    repeat (6) @(negedge clk);

    // latency with rising-edge interrupt on pin0
    drive_pin(0, 1'b1, 1'b1, 1'b1);

    // glitch filter on pin1: longest rejected and shortest accepted pulse
    pulse_pin(1, 3);
    pulse_pin(1, 4);

    // both-edge select and enable masking on pin2
    drive_pin(2, 1'b1, 1'b1, 1'b1);
    drive_pin(2, 1'b0, 1'b1, 1'b1);
    en[2] = 1'b0;
    drive_pin(2, 1'b1, 1'b1, 1'b0);

    // output pin3: data follows, events masked
    drive_pin(3, 1'b1, 1'b0, 1'b0);
    drive_pin(3, 1'b0, 1'b0, 1'b0);
    drive_pin(3, 1'b1, 1'b0, 1'b0);

    // falling-only pin4
    drive_pin(4, 1'b1, 1'b0, 1'b0);
    drive_pin(4, 1'b0, 1'b1, 1'b1);

    // set wins over same-cycle clear on pin0
    drive_pin(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    pins[0] = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 2 + L, K_DATA, 0, 1'b1, "svc_data");
    repeat (3 + L) @(negedge clk);
    clr[0] = 1'b1;
    expect_at(e0 + 3 + L, K_STAT, 0, 1'b1, "svc_status");
    expect_at(e0 + 4 + L, K_IRQ, 0, 1'b1, "svc_irq");
    @(negedge clk);
    clr[0] = 1'b0;
    repeat (3) @(negedge clk);
    clear_pin(0);

    // reset in the middle of a debounce count
    @(negedge clk);
    pins[6] = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 3 + L, K_STAT, 6, 1'b1, "pre_rst_status");
    expect_at(e0 + 4 + L, K_IRQ, 0, 1'b1, "pre_rst_irq");
    repeat (5 + L) @(negedge clk);
    pins[5] = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    assert (data === '0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL async_rst_data: observed %h expected 00", data); end
    total_cnt++;
    assert (status === '0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL async_rst_status: observed %h expected 00", status); end
    total_cnt++;
    assert (irq === 1'b0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL async_rst_irq: observed %b expected 0", irq); end

    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    exp_st = pins & oe_n & (any | pos);
    for (int i = 0; i < W; i++) begin
      expect_at(e0 + 1 + L, K_DATA, i, 1'b0, "rel_data_hold");
      expect_at(e0 + 2 + L, K_DATA, i, pins[i], "rel_data");
      expect_at(e0 + 3 + L, K_STAT, i, exp_st[i], "rel_status");
    end
    expect_at(e0 + 3 + L, K_IRQ, 0, 1'b0, "rel_irq_pre");
    expect_at(e0 + 4 + L, K_IRQ, 0, |(exp_st & en), "rel_irq");
    repeat (6 + L) @(negedge clk);

    waited = 0;
    while (sbq.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++;
    assert (sbq.size() == 0) pass_cnt++;
    else begin fail_cnt++; $error("FAIL drain: observed %0d pending expected 0", sbq.size()); end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond10.md
# gpio_in_cond10

Input-conditioning stage sitting directly downstream of the GPIO pads, on the `pclk10` domain. It consumes the asynchronous `gpio_pin_in10` bus together with `n_gpio_pin_oe10`, and per pin it does three things: synchronises the input, debounces it, and detects edges. It keeps sticky per-pin interrupt status and raises one combined interrupt to the APB GPIO register block.

## Interface
- `DATA_WIDTH`, default `` `GPIO_DATA_WIDTH10 ``: number of pins.
- `DEB_CNT_W`, default 4: width of the debounce counter and of `deb_limit10`.

Ports (`W` = `DATA_WIDTH`):
- `pclk10`  in  1  sole clock, all logic on the rising edge.
- `n_p_reset10`  in  1  reset. Asynchronous, active-low.
- `gpio_pin_in10`  in  W  raw pad inputs, asynchronous to `pclk10`.
- `n_gpio_pin_oe10`  in  W  output enable, active-low. A 0 marks the pin as an output, and its events are masked.
- `deb_limit10`  in  DEB_CNT_W  extra stable cycles required, shared by all pins.
- `irq_en10`  in  W  per-pin interrupt enable.
- `irq_pos10`  in  W  edge select: 1 = rising, 0 = falling.
- `irq_any10`  in  W  1 = both edges, overrides `irq_pos10`.
- `irq_clr10`  in  W  write-1-to-clear pulse for status, one cycle wide.
- `gpio_data_in10`  out  W  debounced pin value.
- `irq_status10`  out  W  sticky per-pin event flags.
- `irq10`  out  1  combined interrupt.

## Operation
Per-pin pipeline, pin *i*:
- **Sync:** `s1 <= pin`, then `s2 <= s1`.
- **Debounce:**
  - If `s2 == deb`: `cnt <= 0`.
  - Else, if `cnt == deb_limit10`: `deb <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - `cnt` never wraps; it is bounded by `deb_limit10`.
- **Glitch filter:** an `s2` pulse shorter than `deb_limit10`+1 cycles never reaches `deb`.
- **Limit change:** if `deb_limit10` is lowered below the current `cnt`, `cnt` keeps counting and can wrap. The limit is required to be static while pins are active.
- **Edge event:** asserted in the cycle `deb` updates. It is computed from the old and new `deb` as `(rise & (irq_any | irq_pos)) | (fall & (irq_any | ~irq_pos))`, gated by `n_gpio_pin_oe10[i]`.
- **Status:** `status <= (status & ~irq_clr10) | event`. A set in the same cycle as a clear wins.
  - Status is set regardless of `irq_en10`; the enable masks only `irq10`.
- **Interrupt:** `irq10 <= |(status & irq_en10)`, registered.
- `gpio_data_in10` = `deb`, and is updated for output pins too. Only events are masked on output pins.
- **After reset:** `deb` = 0, so a pin held high produces one rising event once synchronised and debounced. Software clears it.

## Timing
- Reset value of every output and internal flop (`s1`, `s2`, `deb`, `cnt`, `status`, `irq10`) is 0.
- Pin change captured at edge 0:
  - `s2` valid at edge 1.
  - `gpio_data_in10` updates at edge 2 + `deb_limit10`.
  - `irq_status10` sets at edge 3 + `deb_limit10`.
  - `irq10` rises at edge 4 + `deb_limit10`.
- Clear: `irq_clr10` high at edge n clears status at n; `irq10` falls at n+1.
- Reset asserted mid-debounce: `cnt` and pending state are discarded immediately. Debounce restarts from `deb` = 0.

## Configuration
- `GPIO_IN_DEBOUNCE_EN` defined: debounce counters are present as above.
- Not defined: counters are removed and `deb_limit10` is ignored. `deb <= s2` every cycle, so `gpio_data_in10` latency is fixed at edge 2. Event, status and interrupt behaviour is otherwise identical.

## Structure
- Package `gpio_in_cond_pkg10` holds:
  - the `DEB_CNT_W` default;
  - the edge-select enum (`EDGE_FALL`, `EDGE_RISE`, `EDGE_ANY`);
  - the counter typedef.
- Sub-module `gpio_pin_filter10` covers one pin (sync + debounce + edge detect) and outputs `deb` and `event`.
  - The top instantiates it W times in a generate loop.
  - Status and interrupt logic live in the top.

## Test plan
- **Latency, limit 3:** `deb_limit10`=3, pin0 0→1 held, `irq_en10[0]`=1, `irq_pos10[0]`=1 → `gpio_data_in10[0]`=1 at edge 5, `irq_status10[0]`=1 at edge 6, `irq10`=1 at edge 7.
- **Glitch filter:** `deb_limit10`=3, pin1 pulse lasting 3 `pclk10` cycles → no change on `gpio_data_in10[1]`, `irq_status10[1]` stays 0. A 4-cycle pulse → two updates and one rising event.
- **Edge select and enable:** `irq_any10[2]`=1, then toggle pin2 1→0 → status set. With `irq_en10[2]`=0 → status set but `irq10` stays 0.
- **Output masking:** `n_gpio_pin_oe10[3]`=0, toggle pin3 → `gpio_data_in10[3]` follows, `irq_status10[3]` stays 0.
- **Set vs clear:** `irq_clr10[0]` pulsed in the same cycle as a new event on pin0 → status stays 1. A clear alone → status 0 and `irq10` 0 one cycle later.
- **Reset mid-debounce:** assert `n_p_reset10` mid-count → all outputs 0 asynchronously. After release with pin high → one rising event after 2 + `deb_limit10` + 1 edges.
